// File: rtl/alu_exec_unit.sv
// Handshaked execution unit for the operaciones_alu op set. It keeps a persistent
// carry flag and runs MULS as a 32-step shift-add; every other op takes one cycle.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op_code,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] result,
  output logic [1:0]  comp,
  output logic        carry,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  typedef enum logic [3:0] {
    OP_ADCS = 4'd0,
    OP_ADD  = 4'd1,
    OP_SBCS = 4'd2,
    OP_SUBS = 4'd3,
    OP_RSBS = 4'd4,
    OP_MULS = 4'd5,
    OP_ANDS = 4'd6,
    OP_ORRS = 4'd7,
    OP_CMP  = 4'd8
  } op_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] acc, mcand, mplier;

  logic [32:0] sum;
  logic [31:0] alu_res, acc_next;
  logic [1:0]  alu_comp;
  logic        alu_c, alu_err;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign acc_next  = mplier[0] ? acc + mcand : acc;

  // Subtractions use a + ~b + cin, so bit 32 is the "no borrow" carry directly.
  always_comb begin
    sum      = '0;
    alu_res  = '0;
    alu_comp = 2'b00;
    alu_c    = carry;
    alu_err  = 1'b0;
    case (op_t'(op_code))
      OP_ADCS: begin
        sum     = {1'b0, a} + {1'b0, b} + {32'd0, carry};
        alu_res = sum[31:0];
        alu_c   = sum[32];
      end
      OP_ADD:  alu_res = a + b;
      OP_SBCS: begin
        sum     = {1'b0, a} + {1'b0, ~b} + {32'd0, carry};
        alu_res = sum[31:0];
        alu_c   = sum[32];
      end
      OP_SUBS: begin
        sum     = {1'b0, a} + {1'b0, ~b} + 33'd1;
        alu_res = sum[31:0];
        alu_c   = sum[32];
      end
      OP_RSBS: begin
        sum     = {1'b0, b} + {1'b0, ~a} + 33'd1;
        alu_res = sum[31:0];
        alu_c   = sum[32];
      end
      OP_ANDS: alu_res = a & b;
      OP_ORRS: alu_res = a | b;
      OP_CMP: begin
        if (a > b)      alu_comp = 2'b01;
        else if (a < b) alu_comp = 2'b10;
        else            alu_comp = 2'b00;
      end
      OP_MULS: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      result <= '0;
      comp   <= 2'b00;
      carry  <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (op_code == OP_MULS) begin
              state  <= MUL;
              cnt    <= '0;
              acc    <= '0;
              mcand  <= a;
              mplier <= b;
            end else begin
              state  <= RESP;
              result <= alu_res;
              comp   <= alu_comp;
              err    <= alu_err;
              carry  <= alu_c;
            end
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state  <= RESP;
            result <= acc_next;
            comp   <= 2'b00;
            err    <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
